clken_gen_multi: RTL and testbench
==================================

Name: clken_gen_multi

Overview:
- Multi-channel successor to the single-channel clock-enable divider.
- Generates NUM_CHANNELS independent one-cycle clock-enable pulse trains from one clock, each channel with its own programmable divisor.
- Divisor changes are double-buffered: a new value takes effect only at that channel's terminal count, so no period is truncated or stretched.
- Sits between the host register interface and the SPI/IO shift engines, which use clken_out bits as bit-rate strobes.

Parameters:
- NUM_CHANNELS, 4, number of independent channels (1..16).
- DIVISOR_WIDTH, 16, width of each divisor and counter.
- CHAN_SEL_WIDTH, 4, width of wr_chan; must satisfy 2**CHAN_SEL_WIDTH >= NUM_CHANNELS.
- DEFAULT_DIVISOR, 0, active divisor of every channel after reset.

Ports:
- clk_in  input  1  sole clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- chan_en  input  NUM_CHANNELS  per-channel run enable.
- sync_in  input  1  synchronous phase-align pulse for all channels.
- wr_en  input  1  divisor write strobe.
- wr_chan  input  CHAN_SEL_WIDTH  target channel of the write.
- wr_divisor  input  DIVISOR_WIDTH  new divisor value.
- wr_err  output  1  one-cycle pulse: write to a nonexistent channel.
- pending  output  NUM_CHANNELS  shadow divisor waiting to be applied.
- clken_out  output  NUM_CHANNELS  one-cycle enable pulses.

Behaviour:
- Reset (async assert, sync release). For every channel: cnt=0, div_active=DEFAULT_DIVISOR, shadow=0, pending=0, clken_out=0. Also wr_err=0.
- Per-channel counter, chan_en=1:
  - If cnt==div_active (terminal count, TC): next cycle cnt=0 and clken_out=1.
  - Otherwise: cnt=cnt+1 and clken_out=0.
  - Period is div_active+1 cycles. Divisor 0 gives clken_out held high continuously.
- First pulse after enable: after chan_en rises with cnt=0, the first pulse appears div_active+1 cycles later.
- Defensive wrap: cnt>div_active is treated as TC. This is unreachable in normal operation.
- chan_en=0:
  - cnt forced to 0 and clken_out=0 next cycle.
  - A pending shadow is applied immediately (div_active<=shadow, pending<=0).
- Divisor write:
  - wr_en=1 with wr_chan<NUM_CHANNELS: shadow[wr_chan]<=wr_divisor and pending[wr_chan]<=1 next cycle.
  - The shadow is applied at the first TC strictly after the write cycle: div_active<=shadow, pending<=0, in the same edge as cnt<=0.
- Write in a TC cycle of the target channel: the TC applies the previous shadow, if any. The new write lands in the shadow and pending stays 1 until the next TC.
- Back-to-back writes before a TC: last write wins; only one update is applied.
- Write to wr_chan>=NUM_CHANNELS: ignored, wr_err=1 for one cycle. Otherwise wr_err=0.
- sync_in=1, overriding TC logic:
  - Every channel gets cnt<=0 and clken_out<=0.
  - Pending shadows are applied.
  - Enabled channels then count in lockstep.
  - A write in the same cycle as sync_in goes to the shadow only and is not applied by that sync.
- Reset mid-count: all state returns to reset values immediately. There is no pulse on release.
- Output: clken_out is registered; there is no combinational path from any input to any output.

Optional Feature:
- Macro: CLKEN_GEN_SQUARE_OUT_EN.
- Defined:
  - Adds output port clk_sq_out [NUM_CHANNELS].
  - Each bit toggles on every clken_out pulse of its channel, giving a 50%-duty square wave of period 2*(div_active+1).
  - Reset value is 0; held when chan_en=0; forced to 0 by sync_in.
- Undefined: the port and its flops are absent; all other behaviour is identical.

Decomposition:
- Package clken_gen_pkg holds:
  - Default parameter constants.
  - typedef div_t (logic [DIVISOR_WIDTH-1:0]).
  - A function computing the required CHAN_SEL_WIDTH from NUM_CHANNELS.
- Sub-module clken_gen_chan holds one channel's counter, div_active, shadow and pending logic, plus the optional square flop. It takes a per-channel write strobe and sync_in.
- Top level instantiates it NUM_CHANNELS times via generate. The top also does write decode and produces wr_err.

Test Plan:
- Reset defaults: release rst_n with DEFAULT_DIVISOR=0 and chan_en=4'b0001 -> clken_out[0] high every cycle; other bits stay 0; pending=0.
- Basic divide: write ch1 divisor 3, pulse sync_in, set chan_en[1]=1 -> clken_out[1] pulses every 4 cycles, first pulse 4 cycles after enable.
- Shadow update: ch1 running at divisor 3; write divisor 7 at cnt=1 -> pending[1]=1. Remaining period still 4 cycles; subsequent periods 8 cycles; pending clears at the TC edge.
- Write at TC: write ch2 divisor 5 exactly in a TC cycle while running at divisor 2 -> the next period is still 3 cycles, then 6; pending[2] stays 1 through one period.
- Sync and error: ch0 at divisor 1 and ch3 at divisor 3, running out of phase; assert sync_in -> both cleared, with coincident pulses every 4 cycles thereafter. Write wr_chan=9 -> wr_err single pulse, no state change.
- Async reset mid-count: assert rst_n low at cnt=2 with clken_out low -> outputs 0 immediately; after release, first pulse div_active+1 cycles later. With CLKEN_GEN_SQUARE_OUT_EN, clk_sq_out=0.

Source files
------------

// File: rtl/clken_gen_pkg.sv
// clken_gen_pkg: shared constants, divisor type and sizing helper for the
// multi-channel clock-enable generator.
package clken_gen_pkg;

    localparam int unsigned DEF_NUM_CHANNELS    = 4;
    localparam int unsigned DEF_DIVISOR_WIDTH   = 16;
    localparam int unsigned DEF_CHAN_SEL_WIDTH  = 4;
    localparam int unsigned DEF_DEFAULT_DIVISOR = 0;
    localparam int unsigned MAX_NUM_CHANNELS    = 16;

    // Divisor / counter word at the default width.
    typedef logic [DEF_DIVISOR_WIDTH-1:0] div_t;

    // Minimum wr_chan width able to address num_channels channels (at least 1).
    function automatic int unsigned chan_sel_width(input int unsigned num_channels);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << w) < num_channels) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/clken_gen_chan.sv
// clken_gen_chan: one channel of the clock-enable generator. Holds the period
// counter, the active divisor and its double-buffered shadow.
// Optional square-wave flop enabled by CLKEN_GEN_SQUARE_OUT_EN.
module clken_gen_chan
    import clken_gen_pkg::*;
#(
    parameter int unsigned DIVISOR_WIDTH   = DEF_DIVISOR_WIDTH,
    parameter int unsigned DEFAULT_DIVISOR = DEF_DEFAULT_DIVISOR
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sync,
    input  logic                     wr,
    input  logic [DIVISOR_WIDTH-1:0] wr_divisor,
    output logic                     pending,
    output logic                     clken
`ifdef CLKEN_GEN_SQUARE_OUT_EN
    ,
    output logic                     sq
`endif
);

    localparam logic [DIVISOR_WIDTH-1:0] RST_DIV = DIVISOR_WIDTH'(DEFAULT_DIVISOR);
    localparam logic [DIVISOR_WIDTH-1:0] ONE     = DIVISOR_WIDTH'(1);

    logic [DIVISOR_WIDTH-1:0] cnt;
    logic [DIVISOR_WIDTH-1:0] cnt_nxt;
    logic [DIVISOR_WIDTH-1:0] div_active;
    logic [DIVISOR_WIDTH-1:0] div_nxt;
    logic [DIVISOR_WIDTH-1:0] shadow;
    logic [DIVISOR_WIDTH-1:0] shadow_nxt;
    logic                     pending_nxt;
    logic                     clken_nxt;
    logic                     tc;
    logic                     apply;

    // Terminal count; anything past the divisor also wraps (defensive).
    assign tc = (cnt >= div_active);

    // Next-state: sync overrides disable, which overrides normal counting.
    always_comb begin
        cnt_nxt     = cnt;
        div_nxt     = div_active;
        shadow_nxt  = shadow;
        pending_nxt = pending;
        clken_nxt   = 1'b0;
        apply       = 1'b0;

        if (sync || !en) begin
            cnt_nxt = '0;
            apply   = pending;
        end else if (tc) begin
            cnt_nxt   = '0;
            clken_nxt = 1'b1;
            apply     = pending;
        end else begin
            cnt_nxt = cnt + ONE;
        end

        // Only a shadow captured before this cycle may be applied now.
        if (apply) begin
            div_nxt     = shadow;
            pending_nxt = 1'b0;
        end

        // A write in this cycle always lands in the shadow and stays pending.
        if (wr) begin
            shadow_nxt  = wr_divisor;
            pending_nxt = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div_active <= RST_DIV;
            shadow     <= '0;
            pending    <= 1'b0;
            clken      <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            div_active <= div_nxt;
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            clken      <= clken_nxt;
        end
    end

`ifdef CLKEN_GEN_SQUARE_OUT_EN
    // Square output: toggles with every enable pulse, cleared by sync.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sq <= 1'b0;
        end else if (sync) begin
            sq <= 1'b0;
        end else if (clken_nxt) begin
            sq <= ~sq;
        end
    end
`endif

endmodule

// File: rtl/clken_gen_multi.sv
// clken_gen_multi: NUM_CHANNELS independent clock-enable pulse generators with
// double-buffered per-channel divisors, shared sync and a write decoder.
// Optional clk_sq_out port enabled by CLKEN_GEN_SQUARE_OUT_EN.
module clken_gen_multi
    import clken_gen_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = DEF_NUM_CHANNELS,
    parameter int unsigned DIVISOR_WIDTH   = DEF_DIVISOR_WIDTH,
    parameter int unsigned CHAN_SEL_WIDTH  = DEF_CHAN_SEL_WIDTH,
    parameter int unsigned DEFAULT_DIVISOR = DEF_DEFAULT_DIVISOR
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [NUM_CHANNELS-1:0]   chan_en,
    input  logic                      sync_in,
    input  logic                      wr_en,
    input  logic [CHAN_SEL_WIDTH-1:0] wr_chan,
    input  logic [DIVISOR_WIDTH-1:0]  wr_divisor,
    output logic                      wr_err,
    output logic [NUM_CHANNELS-1:0]   pending,
    output logic [NUM_CHANNELS-1:0]   clken_out
`ifdef CLKEN_GEN_SQUARE_OUT_EN
    ,
    output logic [NUM_CHANNELS-1:0]   clk_sq_out
`endif
);

    // Reject configurations whose select field cannot reach every channel.
    if ((NUM_CHANNELS < 1) || (NUM_CHANNELS > MAX_NUM_CHANNELS) ||
        (CHAN_SEL_WIDTH < chan_sel_width(NUM_CHANNELS))) begin : g_bad_cfg
        $error("clken_gen_multi: unsupported NUM_CHANNELS/CHAN_SEL_WIDTH");
    end

    logic wr_valid_c;

    // Write targets an existing channel.
    assign wr_valid_c = (32'(wr_chan) < NUM_CHANNELS);

    // Error strobe for writes to channels that do not exist.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_valid_c;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        logic wr_c;

        // Per-channel write strobe from the shared write port.
        assign wr_c = wr_en && (wr_chan == CHAN_SEL_WIDTH'(i));

        clken_gen_chan #(
            .DIVISOR_WIDTH  (DIVISOR_WIDTH),
            .DEFAULT_DIVISOR(DEFAULT_DIVISOR)
        ) u_chan (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .en        (chan_en[i]),
            .sync      (sync_in),
            .wr        (wr_c),
            .wr_divisor(wr_divisor),
            .pending   (pending[i]),
            .clken     (clken_out[i])
`ifdef CLKEN_GEN_SQUARE_OUT_EN
            ,
            .sq        (clk_sq_out[i])
`endif
        );
    end

endmodule

// File: tb/tb_clken_gen_multi.sv
// Self-checking bench for clken_gen_multi: directed vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_clken_gen_multi;
    import clken_gen_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned CSW = 4;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] chan_en;
    logic           sync_in;
    logic           wr_en;
    logic [CSW-1:0] wr_chan;
    logic [DW-1:0]  wr_divisor;
    logic           wr_err;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] clken_out;
`ifdef CLKEN_GEN_SQUARE_OUT_EN
    logic [NCH-1:0] clk_sq_out;
`endif

    clken_gen_multi #(
        .NUM_CHANNELS   (NCH),
        .DIVISOR_WIDTH  (DW),
        .CHAN_SEL_WIDTH (CSW),
        .DEFAULT_DIVISOR(0)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .chan_en   (chan_en),
        .sync_in   (sync_in),
        .wr_en     (wr_en),
        .wr_chan   (wr_chan),
        .wr_divisor(wr_divisor),
        .wr_err    (wr_err),
        .pending   (pending),
        .clken_out (clken_out)
`ifdef CLKEN_GEN_SQUARE_OUT_EN
        ,
        .clk_sq_out(clk_sq_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // elapsed: cycles already spent in the current period; a period lasts div+1.
    int elapsed [NCH];
    int div_now [NCH];
    int div_new [NCH];
    bit has_new [NCH];
    bit pulse   [NCH];
    bit square  [NCH];
    bit m_err;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            elapsed[c] = 0; div_now[c] = 0; div_new[c] = 0;
            has_new[c] = 1'b0; pulse[c] = 1'b0; square[c] = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_step(input logic [NCH-1:0] en, input logic sy,
                                       input logic we, input logic [CSW-1:0] wch,
                                       input logic [DW-1:0] wd);
        bit take;
        m_err = we && (32'(wch) >= NCH);
        for (int c = 0; c < NCH; c++) begin
            take     = 1'b0;
            pulse[c] = 1'b0;
            if (sy) begin
                elapsed[c] = 0; square[c] = 1'b0; take = has_new[c];
            end else if (!en[c]) begin
                elapsed[c] = 0; take = has_new[c];
            end else if (elapsed[c] + 1 >= div_now[c] + 1) begin
                elapsed[c] = 0; pulse[c] = 1'b1; square[c] = !square[c]; take = has_new[c];
            end else begin
                elapsed[c] = elapsed[c] + 1;
            end
            if (take) begin
                div_now[c] = div_new[c]; has_new[c] = 1'b0;
            end
            if (we && (32'(wch) == c)) begin
                div_new[c] = int'(wd); has_new[c] = 1'b1;
            end
        end
    endfunction

    function automatic logic [NCH-1:0] pack_bits(input int sel);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) begin
            v[c] = (sel == 0) ? pulse[c] : (sel == 1) ? has_new[c] : square[c];
        end
        return v;
    endfunction

    // One clock: DUT and model consume the same inputs, then compare.
    // sync_in and wr_en are one-shot strobes.
    task automatic step();
        logic [NCH-1:0] s_en;
        logic           s_sy, s_we;
        logic [CSW-1:0] s_ch;
        logic [DW-1:0]  s_wd;
        @(posedge clk_in);
        s_en = chan_en; s_sy = sync_in; s_we = wr_en; s_ch = wr_chan; s_wd = wr_divisor;
        #1;
        model_step(s_en, s_sy, s_we, s_ch, s_wd);
        check("model_clken", 32'(clken_out), 32'(pack_bits(0)));
        check("model_pending", 32'(pending), 32'(pack_bits(1)));
        check("model_wr_err", 32'(wr_err), 32'(m_err));
`ifdef CLKEN_GEN_SQUARE_OUT_EN
        check("model_sq", 32'(clk_sq_out), 32'(pack_bits(2)));
`endif
        sync_in = 1'b0;
        wr_en   = 1'b0;
    endtask

    task automatic wait_pulse(input int ch, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (clken_out[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic write_div(input int ch, input int d);
        wr_en = 1'b1; wr_chan = CSW'(ch); wr_divisor = DW'(d);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_clken", 32'(clken_out), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
`ifdef CLKEN_GEN_SQUARE_OUT_EN
        check("rst_sq", 32'(clk_sq_out), 32'd0);
`endif
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic           sy;
        logic           we;
        logic [CSW-1:0] wch;
        logic [DW-1:0]  wd;
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_pend;
        logic           e_err;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset defaults, basic divide by 4 on ch1, invalid channel writes.
        tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 1'b1, 4'd1, 16'd3, 4'b0001, 4'b0010, 1'b0};
        tbl[2]  = '{4'b0001, 1'b1, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0011, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[10] = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0011, 4'b0000, 1'b0};
        tbl[11] = '{4'b0011, 1'b0, 1'b1, 4'd9, 16'd5, 4'b0001, 4'b0000, 1'b1};
        tbl[12] = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[13] = '{4'b0011, 1'b0, 1'b1, 4'd4, 16'd2, 4'b0001, 4'b0000, 1'b1};
        tbl[14] = '{4'b0011, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0011, 4'b0000, 1'b0};

        rst_n = 1'b0; chan_en = '0; sync_in = 1'b0; wr_en = 1'b0;
        wr_chan = '0; wr_divisor = '0;
        model_reset();
        #12;
        check("por_clken", 32'(clken_out), 32'd0);
        check("por_pending", 32'(pending), 32'd0);
        check("por_wr_err", 32'(wr_err), 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            chan_en = tbl[i].en; sync_in = tbl[i].sy; wr_en = tbl[i].we;
            wr_chan = tbl[i].wch; wr_divisor = tbl[i].wd;
            step();
            check($sformatf("tbl%0d_clken", i), 32'(clken_out), 32'(tbl[i].e_clk));
            check($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
            check($sformatf("tbl%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].e_err));
        end

        // Shadow update mid-period on ch1 (running at 3, cnt back at 0).
        step();
        write_div(1, 7);
        step();
        check("shadow_pending_set", 32'(pending[1]), 32'd1);
        wait_pulse(1, 10, n);
        check("shadow_remaining_period", 32'(n), 32'd2);
        check("shadow_pending_clear", 32'(pending[1]), 32'd0);
        wait_pulse(1, 20, n);
        check("shadow_new_period", 32'(n), 32'd8);

        // Write landing exactly in a TC cycle of ch2 (running at 2).
        write_div(2, 2);
        step();
        step();
        check("disabled_apply", 32'(pending[2]), 32'd0);
        chan_en = 4'b0111;
        wait_pulse(2, 10, n);
        check("tc_first_period", 32'(n), 32'd3);
        step();
        step();
        write_div(2, 5);
        step();
        check("tc_write_pulse", 32'(clken_out[2]), 32'd1);
        check("tc_write_pending", 32'(pending[2]), 32'd1);
        step();
        check("tc_hold_pending_a", 32'(pending[2]), 32'd1);
        step();
        check("tc_hold_pending_b", 32'(pending[2]), 32'd1);
        step();
        check("tc_old_period_pulse", 32'(clken_out[2]), 32'd1);
        check("tc_pending_clear", 32'(pending[2]), 32'd0);
        wait_pulse(2, 20, n);
        check("tc_new_period", 32'(n), 32'd6);

        // Sync aligns ch0 (div 1) and ch3 (div 3) running out of phase.
        chan_en = 4'b0000;
        write_div(0, 1);
        step();
        write_div(3, 3);
        step();
        step();
        chan_en = 4'b0001;
        step();
        step();
        step();
        chan_en = 4'b1001;
        step();
        step();
        step();
        sync_in = 1'b1;
        step();
        check("sync_clear", 32'(clken_out & 4'b1001), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            logic [NCH-1:0] e;
            e = '0;
            e[0] = (i % 2 == 0);
            e[3] = (i % 4 == 0);
            step();
            check($sformatf("sync_lockstep%0d", i), 32'(clken_out), 32'(e));
        end
        write_div(9, 123);
        step();
        check("err_pulse", 32'(wr_err), 32'd1);
        check("err_no_pending", 32'(pending), 32'd0);
        step();
        check("err_single", 32'(wr_err), 32'd0);
        check("pre_reset_low", 32'(clken_out[3]), 32'd0);

        // Async reset with ch3 mid-count; default divisor 0 afterwards.
        do_reset();
        step();
        check("post_reset_first_pulse", 32'(clken_out), 32'b1001);

        // Randomized run against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 19) == 0) chan_en = NCH'($urandom);
            sync_in = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) begin
                wr_en = 1'b1;
                wr_chan = ($urandom_range(0, 7) == 0) ? CSW'($urandom_range(4, 15))
                                                      : CSW'($urandom_range(0, 3));
                wr_divisor = DW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 699) == 0) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
